// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port RAM between an instruction-fetch port and a data
// port. Each transaction takes three cycles: an IDLE sample, a one-cycle RAM
// ACCESS and a one-cycle RESP that carries the acknowledge. Data requests
// normally win. A starvation counter lets a waiting fetch win once after
// STARVE_LIMIT consecutive data grants.
//
// Ports
//   clock, clear          system clock, synchronous active-high reset
//   f_req, f_addr         fetch request (held until f_ack) and word address
//   f_rdata, f_ack        fetch read data, valid with the one-cycle f_ack pulse
//   d_req, d_we, d_addr,  data request (held until d_ack), store enable,
//   d_wdata               word address and store data
//   d_rdata, d_ack        data load result, valid with the one-cycle d_ack pulse
//   ram_r, ram_w          RAM read / write strobes (only during ACCESS)
//   ram_addr, ram_din     RAM address and write data
//   ram_dout              RAM read data, combinational from ram_addr
//   ram_start             one-cycle RAM preload strobe after reset
//   busy                  high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        f_req,
  input  logic [8:0]  f_addr,
  output logic [31:0] f_rdata,
  output logic        f_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [8:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        ram_r,
  output logic        ram_w,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        ram_start,
  output logic        busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          gnt_fetch;
  logic          fetch_wins;

  // Fetch only beats a simultaneous data request once the counter saturates.
  assign fetch_wins = f_req && (!d_req || (starve_cnt == CW'(STARVE_LIMIT)));

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= INIT;
      starve_cnt <= '0;
      gnt_fetch  <= 1'b0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      ram_r      <= 1'b0;
      ram_w      <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_start  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        // INIT spends one cycle with ram_start low (the reset edge itself),
        // then one cycle with ram_start high, then hands over to IDLE.
        INIT: begin
          if (!ram_start) begin
            ram_start <= 1'b1;
            busy      <= 1'b1;
          end else begin
            ram_start <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        // The RAM strobes, address and store data are loaded here, so they
        // double as the latched copy of the request for the ACCESS cycle.
        IDLE: begin
          if (f_req || d_req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            gnt_fetch <= fetch_wins;
            if (fetch_wins) begin
              ram_r    <= 1'b1;
              ram_addr <= f_addr;
            end else begin
              ram_r    <= !d_we;
              ram_w    <= d_we;
              ram_addr <= d_addr;
              if (d_we) begin
                ram_din <= d_wdata;
              end
            end
            // Only data grants made while fetch is waiting count as starvation.
            if (!fetch_wins && f_req) begin
              if (starve_cnt != CW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CW'(1);
              end
            end else begin
              starve_cnt <= '0;
            end
          end
        end

        // Capture read data at the end of ACCESS; a store ack leaves
        // d_rdata holding the result of the last load.
        ACCESS: begin
          ram_r <= 1'b0;
          ram_w <= 1'b0;
          state <= RESP;
          if (gnt_fetch) begin
            f_ack   <= 1'b1;
            f_rdata <= ram_dout;
          end else begin
            d_ack <= 1'b1;
            if (ram_r) begin
              d_rdata <= ram_dout;
            end
          end
        end

        RESP: begin
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. A RAM model sits on the RAM side. A transaction-level
// reference model watches the sampled requests at each rising edge. It decides
// the winner from the priority and starvation rules and computes the result
// from its own memory image. It then queues the expected acknowledge. A
// monitor on the falling edge pops that queue whenever the DUT acks. Directed
// sequences cover reset, the fetch/store/load examples, contention, abort and
// input stability. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clock;
  logic        clear;
  logic        f_req;
  logic [8:0]  f_addr;
  logic [31:0] f_rdata;
  logic        f_ack;
  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        ram_r;
  logic        ram_w;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_start;
  logic        busy;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .clear(clear),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_start(ram_start), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM attached to the DUT, plus the reference model's own memory image.
  logic [31:0] ram     [0:511];
  logic [31:0] ref_mem [0:511];

  assign ram_dout = ram_r ? ram[ram_addr] : 32'h0;

  always @(posedge clock) begin
    if (ram_w) ram[ram_addr] <= ram_din;
  end

  typedef struct {
    bit          is_f;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   ack_log[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state, at transaction level.
  int          init_wait = 2;
  bit          fl_valid  = 0;
  bit          fl_stage  = 0;
  bit          fl_is_f   = 0;
  bit          fl_we     = 0;
  logic [8:0]  fl_addr   = '0;
  logic [31:0] fl_wdata  = '0;
  int          starve    = 0;
  logic [31:0] d_last    = '0;
  bit          ack_f_now = 0;
  bit          ack_d_now = 0;
  bit          fw;
  logic [31:0] mdata;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: one step per rising edge using the sampled requests.
  always @(posedge clock) begin
    ack_f_now = 0;
    ack_d_now = 0;
    if (clear) begin
      // A store whose write strobe was already on the RAM still lands.
      if (fl_valid && !fl_stage && fl_we) ref_mem[fl_addr] = fl_wdata;
      fl_valid  = 0;
      init_wait = 2;
      starve    = 0;
      d_last    = '0;
    end else if (init_wait > 0) begin
      init_wait--;
    end else if (fl_valid) begin
      if (fl_stage) begin
        fl_valid = 0;
      end else begin
        fl_stage = 1;
        if (fl_we) begin
          ref_mem[fl_addr] = fl_wdata;
          exp_q.push_back('{is_f: 1'b0, data: d_last});
        end else begin
          mdata = ref_mem[fl_addr];
          if (!fl_is_f) d_last = mdata;
          exp_q.push_back('{is_f: fl_is_f, data: mdata});
        end
        if (fl_is_f) ack_f_now = 1;
        else         ack_d_now = 1;
      end
    end else if (f_req || d_req) begin
      fw       = f_req && (!d_req || starve == STARVE_LIMIT);
      fl_valid = 1;
      fl_stage = 0;
      fl_is_f  = fw;
      fl_we    = fw ? 1'b0 : d_we;
      fl_addr  = fw ? f_addr : d_addr;
      fl_wdata = d_wdata;
      if (fw || !f_req) starve = 0;
      else if (starve < STARVE_LIMIT) starve++;
    end
  end

  // Monitor: protocol invariants every cycle, scoreboard pop on every ack.
  always @(negedge clock) begin
    exp_t e;
    checkOutput("ram_r_and_ram_w", 32'(ram_r & ram_w), 32'h0);
    checkOutput("f_ack_and_d_ack", 32'(f_ack & d_ack), 32'h0);
    if (f_ack || d_ack) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_ack", 32'({f_ack, d_ack}), 32'h0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ack_port", 32'(f_ack), 32'(e.is_f));
        checkOutput("ack_rdata", e.is_f ? f_rdata : d_rdata, e.data);
        ack_log.push_back(f_ack);
      end
    end
  end

  // Random requester behaviour for one cycle, applied at the falling edge.
  task automatic applyStimulus();
    if (ack_f_now) f_req = 1'b0;
    if (ack_d_now) d_req = 1'b0;
    if (!f_req && $urandom_range(0, 2) != 0) begin
      f_req  = 1'b1;
      f_addr = 9'($urandom_range(0, 31));
    end
    if (!d_req && $urandom_range(0, 2) != 0) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = 9'($urandom_range(0, 31));
      d_wdata = $urandom;
    end
    // Scramble the data-port inputs while its transaction is in ACCESS.
    if (fl_valid && !fl_stage && !fl_is_f && $urandom_range(0, 1) == 1) begin
      d_addr  = 9'($urandom_range(0, 511));
      d_wdata = $urandom;
    end
  endtask

  initial begin
    bit exp_order [10];
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    for (int i = 0; i < 512; i++) begin
      ram[i]     = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
      ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    end
    ram[311]     = 32'h00400054;
    ref_mem[311] = 32'h00400054;

    clear = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;

    // Reset, then release: one ram_start pulse, then idle.
    repeat (2) @(negedge clock);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_ram_start", 32'(ram_start), 32'h0);
    checkOutput("reset_acks", 32'({f_ack, d_ack}), 32'h0);
    checkOutput("reset_strobes", 32'({ram_r, ram_w}), 32'h0);
    checkOutput("reset_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("reset_ram_din", ram_din, 32'h0);
    checkOutput("reset_f_rdata", f_rdata, 32'h0);
    checkOutput("reset_d_rdata", d_rdata, 32'h0);
    clear = 1'b0;
    @(negedge clock);
    checkOutput("init_ram_start", 32'(ram_start), 32'h1);
    @(negedge clock);
    checkOutput("idle_ram_start", 32'(ram_start), 32'h0);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    // Fetch read of word 311.
    f_req = 1'b1; f_addr = 9'd311;
    @(negedge clock);
    checkOutput("fetch_ram_r", 32'(ram_r), 32'h1);
    checkOutput("fetch_ram_w", 32'(ram_w), 32'h0);
    checkOutput("fetch_ram_addr", 32'(ram_addr), 32'd311);
    @(negedge clock);
    checkOutput("fetch_ack", 32'(f_ack), 32'h1);
    checkOutput("fetch_rdata", f_rdata, 32'h00400054);
    checkOutput("fetch_ram_r_resp", 32'(ram_r), 32'h0);
    f_req = 1'b0;
    @(negedge clock);
    checkOutput("fetch_back_idle", 32'(busy), 32'h0);

    // Store 0x25 to 0x34, then load it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h034; d_wdata = 32'h25;
    @(negedge clock);
    checkOutput("store_ram_w", 32'(ram_w), 32'h1);
    checkOutput("store_ram_r", 32'(ram_r), 32'h0);
    checkOutput("store_ram_addr", 32'(ram_addr), 32'h34);
    checkOutput("store_ram_din", ram_din, 32'h25);
    @(negedge clock);
    checkOutput("store_ack", 32'(d_ack), 32'h1);
    d_req = 1'b0;
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h034;
    @(negedge clock);
    checkOutput("load_ram_r", 32'(ram_r), 32'h1);
    @(negedge clock);
    checkOutput("load_ack", 32'(d_ack), 32'h1);
    checkOutput("load_rdata", d_rdata, 32'h25);
    d_req = 1'b0;
    @(negedge clock);

    // Contention: both held, expect D,D,D,D,F,D,D,D,D,F.
    ack_log.delete();
    f_req = 1'b1; f_addr = 9'd7; d_req = 1'b1; d_we = 1'b0; d_addr = 9'd5;
    repeat (30) @(negedge clock);
    f_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("contention_count", 32'(ack_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < ack_log.size(); i++) begin
      checkOutput($sformatf("grant_order[%0d]", i), 32'(ack_log[i]), 32'(exp_order[i]));
    end

    // Abort a load with clear during ACCESS, then re-request.
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h010;
    @(negedge clock);
    checkOutput("abort_in_access", 32'(ram_r), 32'h1);
    clear = 1'b1;
    @(negedge clock);
    checkOutput("abort_no_ack", 32'(d_ack), 32'h0);
    checkOutput("abort_ram_start", 32'(ram_start), 32'h0);
    clear = 1'b0;
    @(negedge clock);
    checkOutput("abort_init_pulse", 32'(ram_start), 32'h1);
    @(negedge clock);
    checkOutput("abort_idle", 32'(busy), 32'h0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("abort_rerequest_ack", 32'(d_ack), 32'h1);
    d_req = 1'b0;
    @(negedge clock);

    // Input stability: d_addr changes during ACCESS.
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020;
    @(negedge clock);
    d_addr = 9'h021;
    checkOutput("stable_ram_addr", 32'(ram_addr), 32'h20);
    @(negedge clock);
    checkOutput("stable_ack", 32'(d_ack), 32'h1);
    checkOutput("stable_rdata", d_rdata, (32'h20 * 32'h01010101) ^ 32'hA5A50000);
    d_req = 1'b0;
    @(negedge clock);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      applyStimulus();
      @(negedge clock);
    end
    f_req = 1'b0; d_req = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
